mcu0_seq: RTL and testbench



---
 rtl/mcu0_seq.sv | 215 +++++++++++++++++++++
 tb/tb_mcu0_seq.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu0_seq.sv
// Multi-cycle fetch/decode/memory/execute sequencer for the mcu0 accumulator
// datapath, with a wait-state memory handshake, timeout watchdog and sticky halt.
module mcu0_seq #(
    parameter int TIMEOUT = 15,
    parameter int CW      = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run,
    input  logic [3:0]    op,
    input  logic          z,
    input  logic          mem_ack,
    output logic          mem_req,
    output logic          addr_sel,
    output logic          mw,
    output logic          irw,
    output logic          pcw,
    output logic          pcmux,
    output logic          aw,
    output logic          sww,
    output logic [3:0]    aluop,
    output logic [2:0]    state,
    output logic [CW-1:0] retired,
    output logic          halted,
    output logic          err
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MEMRD  = 3'd2,
        MEMWR  = 3'd3,
        EXEC   = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_LD  = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_JMP = 4'h2;
    localparam logic [3:0] OP_ST  = 4'h3;
    localparam logic [3:0] OP_CMP = 4'h4;
    localparam logic [3:0] OP_JEQ = 4'h5;

    localparam logic [3:0] ALU_ZERO  = 4'h0;
    localparam logic [3:0] ALU_ADD   = 4'h1;
    localparam logic [3:0] ALU_CMP   = 4'hE;
    localparam logic [3:0] ALU_APASS = 4'hF;

    localparam logic [7:0] TIMEOUT_V = 8'(TIMEOUT);

    state_t     cur_state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_next;
    logic       mem_phase;
    logic       timed_out;
    logic       retire;

    assign state = cur_state;

    // A memory request is outstanding in FETCH (only when issuing) and in both memory states.
    always_comb begin
        mem_phase = 1'b0;
        case (cur_state)
            FETCH:        mem_phase = run;
            MEMRD, MEMWR: mem_phase = 1'b1;
            default:      mem_phase = 1'b0;
        endcase
    end

    // An ack in the same cycle the counter reaches TIMEOUT still completes the access.
    assign timed_out = mem_phase && !mem_ack && (wait_cnt == TIMEOUT_V);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_state <= FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state    = cur_state;
        wait_cnt_next = 8'd0;
        retire        = 1'b0;
        if (mem_phase && !mem_ack && !timed_out) begin
            wait_cnt_next = wait_cnt + 8'd1;
        end
        case (cur_state)
            FETCH: begin
                if (run) begin
                    if (mem_ack) begin
                        next_state = DECODE;
                    end else if (timed_out) begin
                        next_state = HALT;
                    end
                end
            end
            DECODE: begin
                case (op)
                    OP_LD, OP_ADD, OP_CMP: next_state = MEMRD;
                    OP_ST:                 next_state = MEMWR;
                    OP_JMP, OP_JEQ:        next_state = EXEC;
                    default:               next_state = HALT;
                endcase
            end
            MEMRD: begin
                if (mem_ack) begin
                    next_state = EXEC;
                end else if (timed_out) begin
                    next_state = HALT;
                end
            end
            MEMWR: begin
                if (mem_ack) begin
                    next_state = FETCH;
                    retire     = 1'b1;
                end else if (timed_out) begin
                    next_state = HALT;
                end
            end
            EXEC: begin
                next_state = FETCH;
                retire     = 1'b1;
            end
            HALT:    next_state = HALT;
            default: next_state = HALT;
        endcase
    end

    // halted tracks entry into HALT; since HALT is only left by reset it stays sticky.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= 8'd0;
            retired  <= '0;
            halted   <= 1'b0;
            err      <= 1'b0;
        end else begin
            wait_cnt <= wait_cnt_next;
            halted   <= (next_state == HALT);
            if (retire) begin
                retired <= retired + CW'(1);
            end
            if (timed_out) begin
                err <= 1'b1;
            end
        end
    end

    // Controls are gated by reset so a pending request or write strobe drops immediately.
    always_comb begin
        mem_req  = 1'b0;
        addr_sel = 1'b0;
        mw       = 1'b0;
        irw      = 1'b0;
        pcw      = 1'b0;
        pcmux    = 1'b0;
        aw       = 1'b0;
        sww      = 1'b0;
        aluop    = ALU_ZERO;
        if (!reset) begin
            case (cur_state)
                FETCH: begin
                    if (run) begin
                        mem_req = 1'b1;
                        if (mem_ack) begin
                            irw = 1'b1;
                            pcw = 1'b1;
                        end
                    end
                end
                MEMRD: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                end
                MEMWR: begin
                    mem_req  = 1'b1;
                    addr_sel = 1'b1;
                    mw       = 1'b1;
                end
                EXEC: begin
                    case (op)
                        OP_LD: begin
                            aw    = 1'b1;
                            aluop = ALU_APASS;
                        end
                        OP_ADD: begin
                            aw    = 1'b1;
                            aluop = ALU_ADD;
                        end
                        OP_CMP: begin
                            sww   = 1'b1;
                            aluop = ALU_CMP;
                        end
                        OP_JMP: begin
                            pcw   = 1'b1;
                            pcmux = 1'b1;
                        end
                        OP_JEQ: begin
                            pcw   = z;
                            pcmux = z;
                        end
                        default: begin
                            aluop = ALU_ZERO;
                        end
                    endcase
                end
                default: begin
                    mem_req = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu0_seq.sv
// Directed testbench for mcu0_seq: each task drives one scenario and checks
// the sequencer against hand-computed state sequences and control values.
module tb_mcu0_seq;

    localparam int TIMEOUT = 15;
    localparam int CW      = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          run = 1'b0;
    logic [3:0]    op = 4'h0;
    logic          z = 1'b0;
    logic          mem_ack = 1'b0;
    logic          mem_req, addr_sel, mw, irw, pcw, pcmux, aw, sww;
    logic [3:0]    aluop;
    logic [2:0]    state;
    logic [CW-1:0] retired;
    logic          halted, err;

    int vec_count  = 0;
    int miss_count = 0;

    int         prog_state[12] = '{0, 1, 2, 4, 0, 1, 2, 4, 0, 1, 3, 0};
    logic [3:0] prog_op[12]    = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h3, 4'h3, 4'h3, 4'h3};
    logic       wait_ack[7]    = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int         wait_state[7]  = '{0, 1, 2, 2, 2, 2, 4};

    mcu0_seq #(.TIMEOUT(TIMEOUT), .CW(CW)) dut (
        .clock(clock), .reset(reset), .run(run), .op(op), .z(z), .mem_ack(mem_ack),
        .mem_req(mem_req), .addr_sel(addr_sel), .mw(mw), .irw(irw), .pcw(pcw),
        .pcmux(pcmux), .aw(aw), .sww(sww), .aluop(aluop), .state(state),
        .retired(retired), .halted(halted), .err(err)
    );

    always #5 clock = ~clock;

    // Inputs change 1 unit after the rising edge; outputs are sampled 1 unit later.
    task automatic drive(input logic [3:0] o, input logic r, input logic zz, input logic ack);
        op = o; run = r; z = zz; mem_ack = ack;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b0; op = 4'h0; z = 1'b0; mem_ack = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1;
        reset = 1'b1; run = 1'b1; mem_ack = 1'b1;
        #2;
        vec_count++;
        if (state !== 3'd0) begin miss_count++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
        vec_count++;
        if (retired !== 16'd0) begin miss_count++; $display("[TB] FAIL reset_retired: got %0d want 0", retired); end
        vec_count++;
        if (halted !== 1'b0 || err !== 1'b0) begin miss_count++; $display("[TB] FAIL reset_flags: got halted=%b err=%b want 0 0", halted, err); end
        vec_count++;
        if ({mem_req, irw, pcw, aw, sww, mw} !== 6'b0 || aluop !== 4'h0) begin
            miss_count++; $display("[TB] FAIL reset_controls: got req=%b irw=%b pcw=%b aluop=%h want all 0", mem_req, irw, pcw, aluop);
        end
        @(posedge clock);
        #1;
        reset = 1'b0; run = 1'b0; mem_ack = 1'b0;
        drive(4'h0, 1'b0, 1'b0, 1'b0);
        vec_count++;
        if (state !== 3'd0 || mem_req !== 1'b0) begin miss_count++; $display("[TB] FAIL reset_idle: got state=%0d req=%b want 0 0", state, mem_req); end
    endtask

    task automatic test_program();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(prog_op[i], (i < 11), 1'b0, 1'b1);
            vec_count++;
            if (state !== 3'(prog_state[i])) begin miss_count++; $display("[TB] FAIL prog_state[%0d]: got %0d want %0d", i + 1, state, prog_state[i]); end
            vec_count++;
            if (aw !== (i == 3 || i == 7)) begin miss_count++; $display("[TB] FAIL prog_aw[%0d]: got %b want %b", i + 1, aw, (i == 3 || i == 7)); end
            vec_count++;
            if (mw !== (i == 10)) begin miss_count++; $display("[TB] FAIL prog_mw[%0d]: got %b want %b", i + 1, mw, (i == 10)); end
            if (i == 11) begin
                vec_count++;
                if (retired !== 16'd3) begin miss_count++; $display("[TB] FAIL prog_retired: got %0d want 3", retired); end
                vec_count++;
                if (mem_req !== 1'b0) begin miss_count++; $display("[TB] FAIL prog_idle_req: got %b want 0", mem_req); end
            end
            tick();
        end
    endtask

    task automatic test_cmp_jeq();
        do_reset();
        drive(4'h4, 1'b1, 1'b0, 1'b1); tick();
        drive(4'h4, 1'b1, 1'b0, 1'b1); tick();
        drive(4'h4, 1'b1, 1'b0, 1'b1); tick();
        drive(4'h4, 1'b1, 1'b0, 1'b1);
        vec_count++;
        if (state !== 3'd4 || sww !== 1'b1 || aluop !== 4'hE) begin
            miss_count++; $display("[TB] FAIL cmp_exec: got state=%0d sww=%b aluop=%h want 4 1 e", state, sww, aluop);
        end
        tick();
        drive(4'h5, 1'b1, 1'b1, 1'b1); tick();
        drive(4'h5, 1'b1, 1'b1, 1'b1); tick();
        drive(4'h5, 1'b1, 1'b1, 1'b1);
        vec_count++;
        if (state !== 3'd4 || pcw !== 1'b1 || pcmux !== 1'b1) begin
            miss_count++; $display("[TB] FAIL jeq_taken: got state=%0d pcw=%b pcmux=%b want 4 1 1", state, pcw, pcmux);
        end
        tick();
        drive(4'h5, 1'b1, 1'b0, 1'b1);
        vec_count++;
        if (retired !== 16'd2) begin miss_count++; $display("[TB] FAIL jeq_taken_retired: got %0d want 2", retired); end
        tick();
        drive(4'h5, 1'b1, 1'b0, 1'b1); tick();
        drive(4'h5, 1'b1, 1'b0, 1'b1);
        vec_count++;
        if (state !== 3'd4 || pcw !== 1'b0 || pcmux !== 1'b0) begin
            miss_count++; $display("[TB] FAIL jeq_not_taken: got state=%0d pcw=%b pcmux=%b want 4 0 0", state, pcw, pcmux);
        end
        tick();
        drive(4'h5, 1'b0, 1'b0, 1'b0);
        vec_count++;
        if (retired !== 16'd3 || state !== 3'd0) begin miss_count++; $display("[TB] FAIL jeq_not_taken_retired: got retired=%0d state=%0d want 3 0", retired, state); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(4'h0, 1'b1, 1'b0, wait_ack[i]);
            vec_count++;
            if (state !== 3'(wait_state[i])) begin miss_count++; $display("[TB] FAIL wait_state[%0d]: got %0d want %0d", i + 1, state, wait_state[i]); end
            tick();
        end
        drive(4'h0, 1'b0, 1'b0, 1'b0);
        vec_count++;
        if (state !== 3'd0 || retired !== 16'd1) begin miss_count++; $display("[TB] FAIL wait_done: got state=%0d retired=%0d want 0 1", state, retired); end
    endtask

    task automatic test_timeout();
        do_reset();
        drive(4'h0, 1'b1, 1'b0, 1'b1); tick();
        drive(4'h0, 1'b1, 1'b0, 1'b0); tick();
        for (int k = 0; k <= TIMEOUT; k++) begin
            drive(4'h0, 1'b1, 1'b0, 1'b0);
            if (k == TIMEOUT) begin
                vec_count++;
                if (state !== 3'd2 || err !== 1'b0) begin miss_count++; $display("[TB] FAIL timeout_last_wait: got state=%0d err=%b want 2 0", state, err); end
            end
            tick();
        end
        drive(4'h0, 1'b1, 1'b0, 1'b0);
        vec_count++;
        if (state !== 3'd5 || err !== 1'b1 || halted !== 1'b1 || mem_req !== 1'b0) begin
            miss_count++; $display("[TB] FAIL timeout_halt: got state=%0d err=%b halted=%b req=%b want 5 1 1 0", state, err, halted, mem_req);
        end
        for (int i = 0; i < 4; i++) begin
            drive(4'h0, logic'(i % 2), 1'b0, 1'b1);
            vec_count++;
            if (state !== 3'd5 || halted !== 1'b1) begin miss_count++; $display("[TB] FAIL halt_sticky[%0d]: got state=%0d halted=%b want 5 1", i, state, halted); end
            tick();
        end
        vec_count++;
        if (retired !== 16'd0) begin miss_count++; $display("[TB] FAIL timeout_retired: got %0d want 0", retired); end
    endtask

    task automatic test_ack_at_timeout();
        do_reset();
        drive(4'h0, 1'b1, 1'b0, 1'b1); tick();
        drive(4'h0, 1'b1, 1'b0, 1'b0); tick();
        for (int k = 0; k < TIMEOUT; k++) begin
            drive(4'h0, 1'b1, 1'b0, 1'b0); tick();
        end
        drive(4'h0, 1'b1, 1'b0, 1'b1);
        vec_count++;
        if (state !== 3'd2) begin miss_count++; $display("[TB] FAIL ack_edge_memrd: got %0d want 2", state); end
        tick();
        drive(4'h0, 1'b0, 1'b0, 1'b0);
        vec_count++;
        if (state !== 3'd4 || err !== 1'b0 || aw !== 1'b1) begin miss_count++; $display("[TB] FAIL ack_edge_exec: got state=%0d err=%b aw=%b want 4 0 1", state, err, aw); end
        tick();
        drive(4'h0, 1'b0, 1'b0, 1'b0);
        vec_count++;
        if (state !== 3'd0 || retired !== 16'd1 || halted !== 1'b0) begin
            miss_count++; $display("[TB] FAIL ack_edge_done: got state=%0d retired=%0d halted=%b want 0 1 0", state, retired, halted);
        end
    endtask

    task automatic test_illegal_op();
        do_reset();
        drive(4'h7, 1'b1, 1'b0, 1'b1); tick();
        drive(4'h7, 1'b0, 1'b0, 1'b0);
        vec_count++;
        if (state !== 3'd1) begin miss_count++; $display("[TB] FAIL illegal_decode: got %0d want 1", state); end
        tick();
        drive(4'h7, 1'b0, 1'b0, 1'b0);
        vec_count++;
        if (state !== 3'd5 || halted !== 1'b1 || err !== 1'b0 || retired !== 16'd0) begin
            miss_count++; $display("[TB] FAIL illegal_halt: got state=%0d halted=%b err=%b retired=%0d want 5 1 0 0", state, halted, err, retired);
        end
    endtask

    task automatic test_run_drop();
        do_reset();
        drive(4'h3, 1'b1, 1'b0, 1'b1); tick();
        drive(4'h3, 1'b0, 1'b0, 1'b0); tick();
        drive(4'h3, 1'b0, 1'b0, 1'b0);
        vec_count++;
        if (state !== 3'd3 || mem_req !== 1'b1) begin miss_count++; $display("[TB] FAIL rundrop_memwr: got state=%0d req=%b want 3 1", state, mem_req); end
        tick();
        drive(4'h3, 1'b0, 1'b0, 1'b1); tick();
        drive(4'h0, 1'b0, 1'b0, 1'b1);
        vec_count++;
        if (state !== 3'd0 || mem_req !== 1'b0 || retired !== 16'd1) begin
            miss_count++; $display("[TB] FAIL rundrop_idle: got state=%0d req=%b retired=%0d want 0 0 1", state, mem_req, retired);
        end
        tick();
        drive(4'h0, 1'b0, 1'b0, 1'b1);
        vec_count++;
        if (state !== 3'd0) begin miss_count++; $display("[TB] FAIL rundrop_stay: got %0d want 0", state); end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        drive(4'h3, 1'b1, 1'b0, 1'b1); tick();
        drive(4'h3, 1'b1, 1'b0, 1'b1); tick();
        drive(4'h3, 1'b1, 1'b0, 1'b1); tick();
        drive(4'h3, 1'b1, 1'b0, 1'b1); tick();
        drive(4'h3, 1'b1, 1'b0, 1'b0); tick();
        drive(4'h3, 1'b1, 1'b0, 1'b0);
        vec_count++;
        if (state !== 3'd3 || mem_req !== 1'b1 || mw !== 1'b1 || retired !== 16'd1) begin
            miss_count++; $display("[TB] FAIL midwr_pending: got state=%0d req=%b mw=%b retired=%0d want 3 1 1 1", state, mem_req, mw, retired);
        end
        reset = 1'b1;
        #1;
        vec_count++;
        if (mem_req !== 1'b0 || mw !== 1'b0 || state !== 3'd0) begin
            miss_count++; $display("[TB] FAIL midwr_async: got req=%b mw=%b state=%0d want 0 0 0", mem_req, mw, state);
        end
        run = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        drive(4'h0, 1'b0, 1'b0, 1'b0);
        vec_count++;
        if (state !== 3'd0 || retired !== 16'd0) begin miss_count++; $display("[TB] FAIL midwr_release: got state=%0d retired=%0d want 0 0", state, retired); end
    endtask

    initial begin
        test_reset();
        test_program();
        test_cmp_jeq();
        test_mem_wait();
        test_timeout();
        test_ack_at_timeout();
        test_illegal_op();
        test_run_drop();
        test_reset_mid_write();
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule
